// File: rtl/instr_loader.sv
// Packs the debug UART byte stream (count, 4 bytes per instruction, mode byte)
// into 32-bit instruction-memory writes and reports the selected run mode.
//
// state | meaning
// IDLE  | waiting for the instruction-count byte
// LOAD  | assembling instruction words and writing them
// MODE  | waiting for a legal run-mode byte
// DONE  | load complete, bytes ignored until restart
module instr_loader #(
  parameter int                NB_DATA   = 32,
  parameter int                NB_BYTE   = 8,
  parameter int                ADDRWIDTH = 7,
  parameter logic [NB_BYTE-1:0] MODE_CONT = 8'h10,
  parameter logic [NB_BYTE-1:0] MODE_STEP = 8'h20
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_restart,
  output logic                 o_en_write,
  output logic [ADDRWIDTH-1:0] o_address,
  output logic [NB_DATA-1:0]   o_inst_load,
  output logic                 o_debug_unit_reg,
  output logic                 o_mode_valid,
  output logic                 o_mode_step,
  output logic                 o_overflow,
  output logic [2:0]           o_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MODE = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;

  localparam int                   DEPTH    = 1 << ADDRWIDTH;
  localparam logic [NB_BYTE-1:0]   ONE_CNT  = 1;
  localparam logic [ADDRWIDTH-1:0] ONE_ADDR = 1;
  localparam logic [ADDRWIDTH-1:0] MAX_ADDR = '1;

  logic [2:0]           state;
  logic [NB_BYTE-1:0]   count;
  logic [NB_BYTE-1:0]   word_cnt;
  logic [1:0]           byte_idx;
  logic [NB_DATA-1:0]   word;
  logic [ADDRWIDTH-1:0] addr;
  logic [NB_DATA-1:0]   next_word;
  logic                 last_word;
  logic                 in_range;
  logic                 legal_mode;

  assign next_word  = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign last_word  = (word_cnt + ONE_CNT) == count;
  assign in_range   = int'(word_cnt) < DEPTH;
  assign legal_mode = (i_rx_data == MODE_CONT) || (i_rx_data == MODE_STEP);
  assign o_state    = state;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= ST_IDLE;
      count            <= '0;
      word_cnt         <= '0;
      byte_idx         <= '0;
      word             <= '0;
      addr             <= '0;
      o_en_write       <= 1'b0;
      o_address        <= '0;
      o_inst_load      <= '0;
      o_debug_unit_reg <= 1'b0;
      o_mode_valid     <= 1'b0;
      o_mode_step      <= 1'b0;
      o_overflow       <= 1'b0;
    end else begin
      o_en_write   <= 1'b0;
      o_mode_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_done) begin
            count      <= i_rx_data;
            o_overflow <= int'(i_rx_data) > DEPTH;
            byte_idx   <= '0;
            word_cnt   <= '0;
            addr       <= '0;
            word       <= '0;
            if (i_rx_data == '0) begin
              state            <= ST_MODE;
              o_debug_unit_reg <= 1'b0;
            end else begin
              state            <= ST_LOAD;
              o_debug_unit_reg <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (i_rx_done) begin
            word     <= next_word;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_cnt <= word_cnt + ONE_CNT;
              // Words past the end of memory are counted but never written,
              // and the address saturates instead of wrapping.
              if (in_range) begin
                o_en_write  <= 1'b1;
                o_address   <= addr;
                o_inst_load <= next_word;
                if (addr != MAX_ADDR) addr <= addr + ONE_ADDR;
              end
              if (last_word) state <= ST_MODE;
            end
          end
        end
        ST_MODE: begin
          // Held one extra cycle after LOAD so the final strobe still sees the mux.
          o_debug_unit_reg <= 1'b0;
          if (i_rx_done && legal_mode) begin
            o_mode_valid <= 1'b1;
            o_mode_step  <= (i_rx_data == MODE_STEP);
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_restart) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
